// File: rtl/dds_ctrl_pkg.sv
// rtl/dds_ctrl_pkg.sv - shared widths, defaults and FSM state encoding for the DDS config arbiter
package dds_ctrl_pkg;

    localparam int FREQ_W          = 48;
    localparam int RATE_W          = 32;
    localparam int CNT_W           = 10;
    localparam int ACK_TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_START   = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/dds_cfg_arbiter_if.sv
// rtl/dds_cfg_arbiter_if.sv - four-phase load handshake and chirp payload towards dds_chirp
interface dds_cfg_arbiter_if;
    import dds_ctrl_pkg::*;

    logic              req;
    logic              ack;
    logic              start;
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] delta_freq;
    logic [RATE_W-1:0] delta_rate;

    modport master (
        output req, start, freq, delta_freq, delta_rate,
        input  ack
    );

    modport slave (
        input  req, start, freq, delta_freq, delta_rate,
        output ack
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dds_cfg_arbiter.sv
// rtl/dds_cfg_arbiter.sv - arbitrates two chirp requesters onto one dds_chirp load/start handshake
module dds_cfg_arbiter
    import dds_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_r0_req,
    input  logic              i_r1_req,
    input  logic [FREQ_W-1:0] i_r0_freq,
    input  logic [FREQ_W-1:0] i_r1_freq,
    input  logic [FREQ_W-1:0] i_r0_dfreq,
    input  logic [FREQ_W-1:0] i_r1_dfreq,
    input  logic [RATE_W-1:0] i_r0_drate,
    input  logic [RATE_W-1:0] i_r1_drate,
    output logic              o_r0_gnt,
    output logic              o_r1_gnt,
    output logic              o_r0_err,
    output logic              o_r1_err,
    output logic              o_busy,
    dds_cfg_arbiter_if.master dds
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              w_ack_s;
    logic              w_grant;
    logic              w_win;
    logic              w_abort;
    logic              w_tmo;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_winner;
    logic              r_rr_ptr;
    logic              r_req;
    logic              r_start;
    logic              r_busy;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_err0;
    logic              r_err1;
    logic [FREQ_W-1:0] r_freq;
    logic [FREQ_W-1:0] r_dfreq;
    logic [RATE_W-1:0] r_drate;

    sync_2ff u_ack_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (dds.ack),
        .o_q     (w_ack_s)
    );

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_tmo     = (w_cnt_inc == CNT_W'(ACK_TIMEOUT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_abort = 1'b0;
        w_win   = r_winner;
        case (r_state)
            ST_IDLE: begin
                // A still-high synchronized ACK is a stale handshake; wait it out.
                if ((i_r0_req || i_r1_req) && !w_ack_s) begin
                    w_grant = 1'b1;
                    w_next  = ST_LOAD;
                    if (i_r0_req && i_r1_req) begin
                        w_win = FIXED_PRIO ? 1'b0 : r_rr_ptr;
                    end else begin
                        w_win = i_r1_req;
                    end
                end
            end
            ST_LOAD: begin
                if (w_ack_s) begin
                    w_next = ST_RELEASE;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (!w_ack_s) begin
                    w_next = ST_START;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            ST_START: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_winner <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_req    <= 1'b0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_freq   <= '0;
            r_dfreq  <= '0;
            r_drate  <= '0;
        end else begin
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_LOAD || r_state == ST_RELEASE) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_grant) begin
                r_winner <= w_win;
                r_rr_ptr <= ~w_win;
                r_freq   <= w_win ? i_r1_freq  : i_r0_freq;
                r_dfreq  <= w_win ? i_r1_dfreq : i_r0_dfreq;
                r_drate  <= w_win ? i_r1_drate : i_r0_drate;
            end
            // Outputs are registered from the next state so they align with the state flop.
            r_req   <= (w_next == ST_LOAD);
            r_start <= (w_next == ST_START);
            r_busy  <= (w_next != ST_IDLE);
            r_gnt0  <= (w_next == ST_DONE) && !r_winner;
            r_gnt1  <= (w_next == ST_DONE) &&  r_winner;
            r_err0  <= w_abort && !r_winner;
            r_err1  <= w_abort &&  r_winner;
        end
    end

    assign dds.req        = r_req;
    assign dds.start      = r_start;
    assign dds.freq       = r_freq;
    assign dds.delta_freq = r_dfreq;
    assign dds.delta_rate = r_drate;
    assign o_r0_gnt       = r_gnt0;
    assign o_r1_gnt       = r_gnt1;
    assign o_r0_err       = r_err0;
    assign o_r1_err       = r_err1;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_dds_cfg_arbiter.sv
// tb/tb_dds_cfg_arbiter.sv - directed scoreboard bench for dds_cfg_arbiter
module tb_dds_cfg_arbiter;
    import dds_ctrl_pkg::*;

    typedef struct {
        logic [1:0]        kind;
        logic [FREQ_W-1:0] freq;
    } exp_t;

    localparam logic [1:0] K_GNT0 = 2'd0;
    localparam logic [1:0] K_GNT1 = 2'd1;
    localparam logic [1:0] K_ERR0 = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r0_req = 1'b0, r1_req = 1'b0, fp_r0_req = 1'b0, fp_r1_req = 1'b0;
    logic [FREQ_W-1:0] r0_freq = 48'd0, r1_freq = 48'd0, r0_dfreq = 48'd0, r1_dfreq = 48'd0;
    logic [RATE_W-1:0] r0_drate = 32'd0, r1_drate = 32'd0;
    logic g0, g1, e0, e1, busy, fg0, fg1, fe0, fe1, fbusy;

    dds_cfg_arbiter_if rr_if ();
    dds_cfg_arbiter_if fp_if ();

    dds_cfg_arbiter #(.ACK_TIMEOUT(20), .FIXED_PRIO(1'b0)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_r0_req(r0_req), .i_r1_req(r1_req),
        .i_r0_freq(r0_freq), .i_r1_freq(r1_freq), .i_r0_dfreq(r0_dfreq), .i_r1_dfreq(r1_dfreq),
        .i_r0_drate(r0_drate), .i_r1_drate(r1_drate),
        .o_r0_gnt(g0), .o_r1_gnt(g1), .o_r0_err(e0), .o_r1_err(e1), .o_busy(busy), .dds(rr_if)
    );

    dds_cfg_arbiter #(.ACK_TIMEOUT(20), .FIXED_PRIO(1'b1)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n), .i_r0_req(fp_r0_req), .i_r1_req(fp_r1_req),
        .i_r0_freq(r0_freq), .i_r1_freq(r1_freq), .i_r0_dfreq(r0_dfreq), .i_r1_dfreq(r1_dfreq),
        .i_r0_drate(r0_drate), .i_r1_drate(r1_drate),
        .o_r0_gnt(fg0), .o_r1_gnt(fg1), .o_r0_err(fe0), .o_r1_err(fe1), .o_busy(fbusy), .dds(fp_if)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_evt    = 0;
    int   n_start  = 0;
    int   fp_n_g0  = 0;
    int   fp_n_g1  = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_evt(input int target, input int bound, output int cyc);
        cyc = 0;
        while (n_evt < target && cyc < bound) begin
            tick();
            cyc++;
        end
    endtask

    // Remote 96 MHz side: ACK follows REQ after ack_dly cycles, or is driven by hand.
    logic [7:0] hist_rr = 8'd0;
    logic [7:0] hist_fp = 8'd0;
    bit   ack_auto = 1'b1;
    logic ack_man  = 1'b0;
    int   ack_dly  = 2;

    initial begin
        rr_if.ack = 1'b0;
        fp_if.ack = 1'b0;
    end

    always @(negedge clk) begin
        hist_rr   = {hist_rr[6:0], rr_if.req};
        hist_fp   = {hist_fp[6:0], fp_if.req};
        rr_if.ack = ack_auto ? hist_rr[ack_dly-1] : ack_man;
        fp_if.ack = hist_fp[ack_dly-1];
    end

    always @(negedge clk) begin
        exp_t e;
        logic [1:0] kind;
        if (rr_if.start) n_start++;
        if (fg0) fp_n_g0++;
        if (fg1) fp_n_g1++;
        if (g0 || g1 || e0 || e1) begin
            chk("pulse_onehot", 64'($countones({g0, g1, e0, e1})), 64'd1);
            kind = g1 ? K_GNT1 : (e0 ? K_ERR0 : (e1 ? 2'd3 : K_GNT0));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("evt_kind", 64'(kind), 64'(e.kind));
                chk("evt_freq", 64'(rr_if.freq), 64'(e.freq));
            end else begin
                chk("evt_expected", 64'(sb.size()), 64'd1);
            end
            n_evt++;
        end
    end

    initial begin
        int cyc;
        int base;
        int st0;
        logic req_at_20;

        r0_freq = 48'hABCD; r1_freq = 48'h1234; r0_dfreq = 48'h55; r0_drate = 32'h77;
        tick(3);
        chk("rst_ctrl", 64'({rr_if.req, rr_if.start, busy, g0, g1, e0, e1}), 64'd0);
        chk("rst_freq", 64'(rr_if.freq), 64'd0);
        chk("rst_dfreq", 64'(rr_if.delta_freq), 64'd0);
        chk("rst_drate", 64'(rr_if.delta_rate), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Single request from requester 0.
        r0_freq = 48'd1000; r0_dfreq = 48'd10; r0_drate = 32'd1;
        st0 = n_start; base = n_evt;
        sb.push_back('{K_GNT0, 48'd1000});
        r0_req = 1'b1;
        wait_evt(base + 1, 12, cyc);
        r0_req = 1'b0;
        chk("single_in_12", 64'(n_evt >= base + 1), 64'd1);
        chk("single_starts", 64'(n_start - st0), 64'd1);
        chk("single_dfreq", 64'(rr_if.delta_freq), 64'd10);
        chk("single_drate", 64'(rr_if.delta_rate), 64'd1);
        tick(3);

        // Round-robin from reset: R0, R1, R0.
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
        r0_freq = 48'd2000; r1_freq = 48'd3000;
        st0 = n_start; base = n_evt;
        sb.push_back('{K_GNT0, 48'd2000});
        sb.push_back('{K_GNT1, 48'd3000});
        sb.push_back('{K_GNT0, 48'd2000});
        r0_req = 1'b1; r1_req = 1'b1;
        wait_evt(base + 3, 60, cyc);
        r0_req = 1'b0; r1_req = 1'b0;
        chk("rr_three_grants", 64'(n_evt - base), 64'd3);
        chk("rr_starts", 64'(n_start - st0), 64'd3);
        tick(3);

        // Payload change after capture is ignored, and held after completion.
        r1_freq = 48'd5000;
        base = n_evt;
        sb.push_back('{K_GNT1, 48'd5000});
        r1_req = 1'b1;
        tick();
        r1_freq = 48'd7000;
        wait_evt(base + 1, 20, cyc);
        r1_req = 1'b0;
        chk("capture_done", 64'(n_evt - base), 64'd1);
        tick(4);
        chk("payload_hold", 64'(rr_if.freq), 64'd5000);

        // Request dropped right after capture still completes.
        r0_freq = 48'd1234;
        base = n_evt;
        sb.push_back('{K_GNT0, 48'd1234});
        r0_req = 1'b1;
        tick();
        r0_req = 1'b0;
        wait_evt(base + 1, 20, cyc);
        chk("drop_done", 64'(n_evt - base), 64'd1);
        tick(3);

        // ACK never returns: abort exactly 20 cycles after entering LOAD.
        ack_auto = 1'b0; ack_man = 1'b0;
        r0_freq = 48'd4321;
        st0 = n_start; base = n_evt; req_at_20 = 1'b0;
        sb.push_back('{K_ERR0, 48'd4321});
        r0_req = 1'b1;
        cyc = 0;
        while (n_evt < base + 1 && cyc < 30) begin
            tick();
            cyc++;
            if (cyc == 20) req_at_20 = rr_if.req;
        end
        r0_req = 1'b0;
        chk("tmo_cycles", 64'(cyc), 64'd21);
        chk("tmo_req_before", 64'(req_at_20), 64'd1);
        chk("tmo_req_after", 64'(rr_if.req), 64'd0);
        chk("tmo_no_start", 64'(n_start - st0), 64'd0);
        tick(3);

        // Reset in RELEASE, then stale ACK after release.
        r0_freq = 48'd999;
        base = n_evt;
        r0_req = 1'b1;
        tick();
        ack_man = 1'b1;
        tick(5);
        chk("release_state", 64'({rr_if.req, busy}), 64'b01);
        rst_n = 1'b0; r0_req = 1'b0;
        #1;
        chk("mid_rst_ctrl", 64'({rr_if.req, rr_if.start, busy, g0, g1, e0, e1}), 64'd0);
        chk("mid_rst_freq", 64'(rr_if.freq), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        r0_freq = 48'd888;
        r0_req = 1'b1;
        tick(5);
        chk("stale_ack_hold", 64'({rr_if.req, busy}), 64'd0);
        chk("rst_no_evt", 64'(n_evt - base), 64'd0);
        sb.push_back('{K_GNT0, 48'd888});
        ack_auto = 1'b1;
        wait_evt(base + 1, 25, cyc);
        r0_req = 1'b0;
        chk("stale_then_grant", 64'(n_evt - base), 64'd1);
        tick(3);

        // Fixed priority: requester 0 always wins.
        fp_r0_req = 1'b1; fp_r1_req = 1'b1;
        cyc = 0;
        while (fp_n_g0 < 3 && cyc < 80) begin
            tick();
            cyc++;
        end
        fp_r0_req = 1'b0; fp_r1_req = 1'b0;
        tick(3);
        chk("fp_r0_grants", 64'(fp_n_g0), 64'd3);
        chk("fp_r1_grants", 64'(fp_n_g1), 64'd0);

        tick(5);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_cfg_arbiter.md
DDS_CFG_ARBITER -- requirements
Module: dds_cfg_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1023: CLK cycles allowed for each ACK edge before abort.
REQ-002 Parameter FIXED_PRIO, default 0: 0 = round-robin arbitration; 1 = requester 0 always wins.
REQ-003 CLK  in  1  system clock (48 MHz domain); all logic on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 R0_REQ, R1_REQ  in  1 each  level request; held until GNT or ERR pulse.
REQ-006 R0_FREQ, R1_FREQ  in  48 each  chirp start frequency word.
REQ-007 R0_DFREQ, R1_DFREQ  in  48 each  chirp frequency step.
REQ-008 R0_DRATE, R1_DRATE  in  32 each  chirp step rate.
REQ-009 R0_GNT, R1_GNT  out  1 each  one-cycle pulse: load and start completed.
REQ-010 R0_ERR, R1_ERR  out  1 each  one-cycle pulse: ACK timeout, request aborted.
REQ-011 DDS_freq, DDS_delta_freq, DDS_delta_rate  out  48/48/32  registered payload to dds_chirp.
REQ-012 REQ  out  1  four-phase load request to dds_chirp.
REQ-013 ACK  in  1  load acknowledge from the 96 MHz domain (asynchronous to CLK).
REQ-014 DDS_start  out  1  one-cycle chirp start pulse.
REQ-015 BUSY  out  1  high in every state except IDLE.

Function
REQ-016 ACK passes through a 2-flop synchronizer; all FSM decisions use the synchronized ACK (ACK_s).
REQ-017 FSM states: IDLE, LOAD, RELEASE, START, DONE.
REQ-018 IDLE: at the edge where any Rx_REQ=1 and ACK_s=0, select the winner, capture its payload into the DDS_* registers, set REQ=1, go to LOAD.
REQ-019 IDLE with ACK_s=1 (stale handshake): stay in IDLE until ACK_s=0.
REQ-020 Round-robin: on simultaneous requests, grant the requester not served last; after reset, requester 0 wins first.
REQ-021 LOAD: hold REQ=1 until ACK_s=1, then REQ=0 and go to RELEASE.
REQ-022 RELEASE: wait for ACK_s=0, then go to START.
REQ-023 START: DDS_start=1 for exactly one cycle, then go to DONE.
REQ-024 DONE: winner's Rx_GNT=1 for one cycle, then return to IDLE; no new grant in the DONE cycle.
REQ-025 Timeout: a 10-bit counter clears on each state entry and increments in LOAD and RELEASE; reaching ACK_TIMEOUT forces REQ=0, pulses the winner's Rx_ERR, returns to IDLE, and issues no DDS_start.
REQ-026 Payload is captured only in the IDLE grant cycle; later input changes are ignored until the next grant.
REQ-027 Rx_REQ dropped after capture: the sequence still completes and GNT still pulses.
REQ-028 DDS_* registers hold the last granted payload until the next grant.
REQ-029 Minimum latency with ideal ACK, Rx_REQ to Rx_GNT: 1 (grant) + 2 (sync) + 1 + 2 (sync) + 1 + 1 = 8 cycles.
REQ-030 Only one of R0_GNT/R1_GNT/R0_ERR/R1_ERR is high in any cycle.

Reset
REQ-031 While RESET=0, all outputs are 0: REQ, DDS_start, GNT, ERR, BUSY, DDS_freq, DDS_delta_freq, DDS_delta_rate.
REQ-032 While RESET=0, state=IDLE, the round-robin pointer selects requester 0, the synchronizer flops are 0, and the timeout counter is 0.
REQ-033 Reset asserted mid-handshake aborts with no GNT/ERR; after release, a stale ACK_s is handled by REQ-019.

Structure
REQ-034 Shared package dds_ctrl_pkg holds the FSM state enum, FREQ_W=48, RATE_W=32, and the default ACK_TIMEOUT.
REQ-035 The ACK synchronizer is a separate sub-module, sync_2ff; everything else is flat.

Verification
REQ-036 Single request: R0_REQ=1, FREQ=1000, DFREQ=10, DRATE=1; ACK follows REQ after 2 cycles -> DDS_freq=1000, one DDS_start, R0_GNT within 12 cycles.
REQ-037 Simultaneous R0_REQ/R1_REQ held, FIXED_PRIO=0 -> grants in order R0, R1, R0; two DDS_start pulses per two grants.
REQ-038 ACK never asserted, ACK_TIMEOUT=20 -> REQ=0 and R0_ERR pulse exactly 20 cycles after entering LOAD; no DDS_start.
REQ-039 R1_FREQ changed from 5000 to 7000 one cycle after grant -> DDS_freq stays 5000.
REQ-040 RESET low during RELEASE -> all outputs 0 immediately; with ACK still high after release, no new REQ until ACK falls.
REQ-041 FIXED_PRIO=1, both requests held continuously -> R0 is granted every time; R1 is never granted.
